// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (requester 0) and
// load/store (requester 1). Round-robin grant, latches the winner's request
// onto the port, holds it until mem_ready or timeout, then pulses done/err.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   reqN_valid/addr/      request from requester N (held until own done/err)
//   wdata/we
//   doneN, errN           one-cycle completion / timeout pulse to requester N
//   rdata                 registered read data, valid with doneN
//   mem_sel               2:1 select of the granted requester
//   mem_valid             access active on the port
//   mem_addr/wdata/we     latched request fields driven to memory
//   mem_ready, mem_rdata  memory completion and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req0_we,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic              req1_we,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_sel,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                is_err_q, is_err_d;
   logic                sel_q, sel_d;
   logic                valid_q, valid_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                grant_vld;
   logic                grant_sel;
   logic                timer_expired;

   // On a tie the requester that did not win last time goes next; otherwise
   // whichever single requester is valid wins.
   assign grant_vld     = req0_valid | req1_valid;
   assign grant_sel     = (req0_valid & req1_valid) ? ~last_q : req1_valid;
   assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         timer_q  <= '0;
         is_err_q <= 1'b0;
         sel_q    <= 1'b0;
         valid_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         timer_q  <= timer_d;
         is_err_q <= is_err_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      timer_d  = timer_q;
      is_err_d = is_err_q;
      sel_d    = sel_q;
      valid_d  = valid_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               sel_d   = grant_sel;
               last_d  = grant_sel;
               addr_d  = grant_sel ? req1_addr  : req0_addr;
               wdata_d = grant_sel ? req1_wdata : req0_wdata;
               we_d    = grant_sel ? req1_we    : req0_we;
               timer_d = '0;
               valid_d = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // mem_ready takes priority over a timeout landing in the same cycle
            if (mem_ready) begin
               rdata_d  = mem_rdata;
               is_err_d = 1'b0;
               valid_d  = 1'b0;
               state_d  = RESP;
            end else if (timer_expired) begin
               is_err_d = 1'b1;
               valid_d  = 1'b0;
               state_d  = RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      done0     = (state_q == RESP) && !is_err_q && !sel_q;
      done1     = (state_q == RESP) && !is_err_q &&  sel_q;
      err0      = (state_q == RESP) &&  is_err_q && !sel_q;
      err1      = (state_q == RESP) &&  is_err_q &&  sel_q;
      rdata     = rdata_q;
      mem_sel   = sel_q;
      mem_valid = valid_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_we    = we_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level
// model of the arbiter.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_wdata, req1_wdata;
   logic          req0_we, req1_we;
   logic          done0, done1, err0, err1;
   logic [DW-1:0] rdata;
   logic          mem_sel, mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_we(req0_we),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_we(req1_we),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
      .mem_sel(mem_sel), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Transaction-level model: who owns the port, how many busy cycles have
   // elapsed, who is being answered this cycle, and the values on the port.
   int            m_owner;
   int            m_resp;
   bit            m_resp_err;
   int            m_waited;
   int            m_last;
   int            m_sel;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_we;
   logic [DW-1:0] m_rdata;

   // Random requester state
   logic          rv[2];
   logic [AW-1:0] ra[2];
   logic [DW-1:0] rd[2];
   logic          rw[2];
   int            ready_at;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_owner = -1; m_resp = -1; m_resp_err = 0; m_waited = 0; m_last = 1;
         m_sel = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_rdata = '0;
      end else if (m_resp >= 0) begin
         m_resp = -1;
      end else if (m_owner >= 0) begin
         if (mem_ready) begin
            m_rdata = mem_rdata; m_resp = m_owner; m_resp_err = 0; m_owner = -1;
         end else if (m_waited + 1 == TO) begin
            m_resp = m_owner; m_resp_err = 1; m_owner = -1;
         end else begin
            m_waited++;
         end
      end else if (req0_valid || req1_valid) begin
         int w;
         w = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
         m_owner = w; m_last = w; m_sel = w; m_waited = 0;
         m_addr  = (w == 1) ? req1_addr  : req0_addr;
         m_wdata = (w == 1) ? req1_wdata : req0_wdata;
         m_we    = (w == 1) ? req1_we    : req0_we;
      end
   endtask

   task automatic compare_all();
      chk("mem_valid", 64'(mem_valid), 64'(m_owner >= 0));
      chk("mem_sel",   64'(mem_sel),   64'(m_sel));
      chk("mem_addr",  64'(mem_addr),  64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      chk("mem_we",    64'(mem_we),    64'(m_we));
      chk("rdata",     64'(rdata),     64'(m_rdata));
      chk("done0", 64'(done0), 64'(m_resp == 0 && !m_resp_err));
      chk("done1", 64'(done1), 64'(m_resp == 1 && !m_resp_err));
      chk("err0",  64'(err0),  64'(m_resp == 0 &&  m_resp_err));
      chk("err1",  64'(err1),  64'(m_resp == 1 &&  m_resp_err));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive_random();
      rst_n = ($urandom_range(0, 299) != 0);
      for (int w = 0; w < 2; w++) begin
         if (m_resp == w) begin
            rv[w] = 1'($urandom_range(0, 1));
            ra[w] = $urandom; rd[w] = $urandom; rw[w] = 1'($urandom_range(0, 1));
         end else if (m_owner == w) begin
            if (rv[w] && $urandom_range(0, 9) == 0) rv[w] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
               ra[w] = $urandom; rd[w] = $urandom; rw[w] = 1'($urandom_range(0, 1));
            end
         end else if (!rv[w] && $urandom_range(0, 3) == 0) begin
            rv[w] = 1'b1;
            ra[w] = $urandom; rd[w] = $urandom; rw[w] = 1'($urandom_range(0, 1));
         end
      end
      if (m_owner >= 0) begin
         if (m_waited == 0) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6)       ready_at = r / 2;
            else if (r == 6) ready_at = int'($urandom_range(3, 10));
            else if (r == 7) ready_at = TO - 1;
            else             ready_at = TO + 5;
         end
         mem_ready = (m_waited == ready_at);
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
      end
      mem_rdata  = $urandom;
      req0_valid = rv[0]; req0_addr = ra[0]; req0_wdata = rd[0]; req0_we = rw[0];
      req1_valid = rv[1]; req1_addr = ra[1]; req1_wdata = rd[1]; req1_we = rw[1];
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0; req0_we = 1'b0;
      req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0; req1_we = 1'b0;
      mem_ready = 1'b0; mem_rdata = '0;
      ready_at = 0;
      @(negedge clk);
      tick();
      tick();
      chk("reset_mem_valid", 64'(mem_valid), 64'd0);
      chk("reset_rdata", 64'(rdata), 64'd0);
      rst_n = 1'b1;

      // Single read
      req0_valid = 1'b1; req0_addr = 32'h100; req0_we = 1'b0;
      tick();
      chk("read_mem_valid", 64'(mem_valid), 64'd1);
      chk("read_mem_sel", 64'(mem_sel), 64'd0);
      chk("read_mem_addr", 64'(mem_addr), 64'h100);
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      chk("read_done0", 64'(done0), 64'd1);
      chk("read_rdata", 64'(rdata), 64'hDEADBEEF);
      chk("read_valid_low", 64'(mem_valid), 64'd0);
      req0_valid = 1'b0; mem_ready = 1'b0;
      tick();
      chk("read_done0_gone", 64'(done0), 64'd0);
      tick();

      // Tie after reset alternates 0,1,0,1
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 32'h10; req1_addr = 32'h14;
      mem_ready = 1'b1; mem_rdata = 32'h1234;
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("tie_sel", 64'(mem_sel), 64'(t % 2));
         tick();
         chk("tie_done", 64'({done1, done0}), (t % 2 == 1) ? 64'd2 : 64'd1);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; mem_ready = 1'b0;
      tick();

      // Wait states and latched fields
      req1_valid = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h5A5A5A5A; req1_we = 1'b1;
      tick();
      req1_addr = 32'hFFF0; req1_wdata = 32'h0; req1_we = 1'b0;
      tick();
      tick();
      chk("hold_addr", 64'(mem_addr), 64'h20);
      chk("hold_wdata", 64'(mem_wdata), 64'h5A5A5A5A);
      chk("hold_we", 64'(mem_we), 64'd1);
      mem_ready = 1'b1;
      tick();
      chk("wait_done1", 64'(done1), 64'd1);
      req1_valid = 1'b0; mem_ready = 1'b0;
      tick();

      // Timeout: no mem_ready
      req0_valid = 1'b1; req0_addr = 32'h40;
      tick();
      n = 0;
      while (mem_valid && n < 40) begin
         n++;
         tick();
      end
      chk("timeout_busy_cycles", 64'(n), 64'd16);
      chk("timeout_err0", 64'(err0), 64'd1);
      chk("timeout_no_done0", 64'(done0), 64'd0);
      req0_valid = 1'b0;
      tick();

      // mem_ready on the last allowed busy cycle completes normally
      req0_valid = 1'b1;
      tick();
      for (int i = 1; i < TO; i++) tick();
      mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
      tick();
      chk("late_done0", 64'(done0), 64'd1);
      chk("late_no_err0", 64'(err0), 64'd0);
      chk("late_rdata", 64'(rdata), 64'hCAFE0001);
      req0_valid = 1'b0; mem_ready = 1'b0;
      tick();

      // Reset during BUSY, then tie grants requester 0
      req0_valid = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      chk("rst_busy_valid", 64'(mem_valid), 64'd0);
      rst_n = 1'b1; req1_valid = 1'b1; mem_ready = 1'b1;
      tick();
      chk("rst_tie_sel", 64'(mem_sel), 64'd0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0; mem_ready = 1'b0;
      tick();
      tick();

      // Randomized traffic
      for (int w = 0; w < 2; w++) begin
         rv[w] = 1'b0; ra[w] = '0; rd[w] = '0; rw[w] = 1'b0;
      end
      for (int i = 0; i < 4000; i++) begin
         drive_random();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
